// File: rtl/ddr_pkg.sv
// Shared types and constants for the controller read-data capture path.
package ddr_pkg;

  localparam int DQ_W      = 8;
  localparam int RD_WORD_W = 64;

  localparam logic [3:0] BL4 = 4'd4;
  localparam logic [3:0] BL8 = 4'd8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PRE,
    PRE,
    CAPTURE,
    PUSH
  } rd_cap_state_e;

  // Anything other than BL4 runs as a full BL8 burst.
  function automatic logic [3:0] norm_bl(input logic [3:0] bl);
    return (bl == BL4) ? BL4 : BL8;
  endfunction

  function automatic logic [1:0] norm_pre(input logic [1:0] pre);
    return (pre == 2'd0) ? 2'd1 : pre;
  endfunction

endpackage

// File: rtl/rd_capture_fifo.sv
// Synchronous word queue for captured read data; a push into a full queue is
// accepted only when a pop happens in the same cycle.
module rd_capture_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             CK_t,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the queue is empty.
  always_ff @(posedge CK_t) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ctrl_rd_capture.sv
// Read-data capture: waits for the DQS preamble, samples BL beats of DQ and queues the word.
// Build option: define RD_DBI_EN to add the dbi_n port and un-invert beats flagged by it.
module ctrl_rd_capture
  import ddr_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RD_TIMEOUT = 16
) (
  input  logic                 CK_t,
  input  logic                 reset,
  input  logic                 rd_start,
  input  logic [1:0]           preamble,
  input  logic [3:0]           burst_length,
  input  logic                 dqs_t,
  input  logic                 dqs_c,
  input  logic [DQ_W-1:0]      dq,
`ifdef RD_DBI_EN
  input  logic                 dbi_n,
`endif
  output logic [RD_WORD_W-1:0] rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic                 busy,
  output logic                 rd_timeout,
  output logic                 rd_overflow
);

  localparam int               TMR_W    = $clog2(RD_TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(RD_TIMEOUT - 1);

  rd_cap_state_e          state;
  rd_cap_state_e          next_state;
  logic [1:0]             pre_len;
  logic [1:0]             pre_cnt;
  logic [3:0]             bl_len;
  logic [3:0]             beat;
  logic [TMR_W-1:0]       timer;
  logic [RD_WORD_W-1:0]   shift_reg;
  logic [DQ_W-1:0]        beat_data;
  logic                   preamble_seen;
  logic                   fifo_push;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   set_timeout;
  logic                   set_overflow;

  assign preamble_seen = dqs_t && !dqs_c;

`ifdef RD_DBI_EN
  assign beat_data = dbi_n ? dq : ~dq;
`else
  assign beat_data = dq;
`endif

  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (rd_start) next_state = WAIT_PRE;
      WAIT_PRE: begin
        if (preamble_seen)          next_state = (pre_len == 2'd1) ? CAPTURE : PRE;
        else if (timer == TMO_LAST) next_state = IDLE;
      end
      PRE:      if (pre_cnt == 2'd1) next_state = CAPTURE;
      CAPTURE:  if (beat == bl_len - 4'd1) next_state = PUSH;
      PUSH:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b0;
    fifo_push    = 1'b0;
    set_timeout  = 1'b0;
    set_overflow = 1'b0;
    case (state)
      WAIT_PRE: begin
        busy        = 1'b1;
        set_timeout = !preamble_seen && (timer == TMO_LAST);
      end
      PRE, CAPTURE: busy = 1'b1;
      PUSH: begin
        busy         = 1'b1;
        fifo_push    = 1'b1;
        set_overflow = fifo_full && !rd_ready;
      end
      default: ;
    endcase
  end

  // Burst parameters are frozen at rd_start; the shift register starts clear so short bursts zero-fill.
  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      pre_len   <= 2'd1;
      pre_cnt   <= '0;
      bl_len    <= BL8;
      beat      <= '0;
      timer     <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_start) begin
            pre_len   <= norm_pre(preamble);
            bl_len    <= norm_bl(burst_length);
            pre_cnt   <= '0;
            beat      <= '0;
            timer     <= '0;
            shift_reg <= '0;
          end
        end
        WAIT_PRE: begin
          if (preamble_seen) pre_cnt <= pre_len - 2'd1;
          else               timer   <= timer + 1'b1;
        end
        PRE:     pre_cnt <= pre_cnt - 2'd1;
        CAPTURE: begin
          shift_reg[{beat[2:0], 3'b000} +: DQ_W] <= beat_data;
          beat <= beat + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      rd_timeout  <= 1'b0;
      rd_overflow <= 1'b0;
    end else begin
      if (set_timeout)  rd_timeout  <= 1'b1;
      if (set_overflow) rd_overflow <= 1'b1;
    end
  end

  rd_capture_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RD_WORD_W)
  ) u_fifo (
    .CK_t      (CK_t),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (shift_reg),
    .pop       (rd_ready),
    .head      (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rd_valid = !fifo_empty;

endmodule

// File: tb/tb_ctrl_rd_capture.sv
// Self-checking bench for ctrl_rd_capture: table-driven bursts plus timeout, overflow and reset sequences.
`timescale 1ns/1ps
module tb_ctrl_rd_capture;

  logic        CK_t = 1'b0;
  logic        reset = 1'b1;
  logic        rd_start = 1'b0;
  logic [1:0]  preamble = 2'd0;
  logic [3:0]  burst_length = 4'd0;
  logic        dqs_t = 1'b0;
  logic        dqs_c = 1'b1;
  logic [7:0]  dq = 8'd0;
`ifdef RD_DBI_EN
  logic        dbi_n = 1'b1;
`endif
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic        busy;
  logic        rd_timeout;
  logic        rd_overflow;

  int tests = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  bl;
    logic [1:0]  pre;
    int          gap;
    logic [63:0] beats;
    logic [7:0]  dbi_mask;
    logic [63:0] exp_word;
  } vec_t;

  vec_t vecs[5];

  always #5 CK_t = ~CK_t;

  ctrl_rd_capture #(
    .FIFO_DEPTH (4),
    .RD_TIMEOUT (16)
  ) dut (
    .CK_t         (CK_t),
    .reset        (reset),
    .rd_start     (rd_start),
    .preamble     (preamble),
    .burst_length (burst_length),
    .dqs_t        (dqs_t),
    .dqs_c        (dqs_c),
    .dq           (dq),
`ifdef RD_DBI_EN
    .dbi_n        (dbi_n),
`endif
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .busy         (busy),
    .rd_timeout   (rd_timeout),
    .rd_overflow  (rd_overflow)
  );

  task automatic tick();
    @(posedge CK_t);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    tick();
  endtask

  task automatic apply_stimulus(input logic [3:0] bl, input logic [1:0] pre, input int gap,
                                input logic [63:0] beats, input logic [7:0] dbi_mask,
                                input bit pop_at_push, output logic push_busy, output logic push_valid);
    int n_pre;
    int n_bl;
    n_pre = (pre == 2'd0) ? 1 : int'(pre);
    n_bl  = (bl == 4'd4) ? 4 : 8;
    rd_start = 1'b1;
    preamble = pre;
    burst_length = bl;
    tick();
    rd_start = 1'b0;
    for (int g = 0; g < gap; g++) begin
      dqs_t = 1'b0; dqs_c = 1'b1;
      tick();
    end
    for (int p = 0; p < n_pre; p++) begin
      dqs_t = 1'b1; dqs_c = 1'b0;
      tick();
    end
    dqs_t = 1'b0; dqs_c = 1'b1;
    for (int k = 0; k < n_bl; k++) begin
      dq = beats[8*k +: 8];
`ifdef RD_DBI_EN
      dbi_n = !dbi_mask[k];
`endif
      tick();
    end
    dq = 8'd0;
`ifdef RD_DBI_EN
    dbi_n = 1'b1;
`endif
    push_busy  = busy;
    push_valid = rd_valid;
    if (pop_at_push) rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic        pb;
    logic        pv;
    logic [7:0]  b;
    logic [63:0] w;

    vecs[0] = '{4'd8, 2'd1, 0,  64'h8877665544332211, 8'h00, 64'h8877665544332211};
    vecs[1] = '{4'd4, 2'd2, 3,  64'h00000000DDCCBBAA, 8'h00, 64'h00000000DDCCBBAA};
    vecs[2] = '{4'd5, 2'd0, 1,  64'h0807060504030201, 8'h00, 64'h0807060504030201};
`ifdef RD_DBI_EN
    vecs[3] = '{4'd4, 2'd1, 0,  64'hFFFFFFFF5634120F, 8'h03, 64'h000000005634EDF0};
`else
    vecs[3] = '{4'd4, 2'd1, 0,  64'hFFFFFFFF5634120F, 8'h03, 64'h000000005634120F};
`endif
    vecs[4] = '{4'd8, 2'd2, 15, 64'hC33C5AA500FF00FF, 8'h00, 64'hC33C5AA500FF00FF};

    #2;
    check_output("reset rd_valid", rd_valid, 0);
    check_output("reset rd_data", rd_data, 0);
    check_output("reset busy", busy, 0);
    check_output("reset rd_timeout", rd_timeout, 0);
    check_output("reset rd_overflow", rd_overflow, 0);
    #10;
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(vecs[i].bl, vecs[i].pre, vecs[i].gap, vecs[i].beats, vecs[i].dbi_mask, 1'b0, pb, pv);
      check_output($sformatf("v%0d busy at push", i), pb, 1);
      check_output($sformatf("v%0d valid at push", i), pv, 0);
      check_output($sformatf("v%0d busy after", i), busy, 0);
      check_output($sformatf("v%0d valid after", i), rd_valid, 1);
      check_output($sformatf("v%0d data", i), rd_data, vecs[i].exp_word);
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      check_output($sformatf("v%0d valid popped", i), rd_valid, 0);
      check_output($sformatf("v%0d data popped", i), rd_data, 0);
    end
    check_output("no timeout after vectors", rd_timeout, 0);
    check_output("no overflow after vectors", rd_overflow, 0);

    // Missing preamble: dqs parked at 1/1 for the whole window.
    rd_start = 1'b1; preamble = 2'd1; burst_length = 4'd8;
    tick();
    rd_start = 1'b0;
    dqs_t = 1'b1; dqs_c = 1'b1;
    check_output("timeout busy start", busy, 1);
    for (int c = 0; c < 15; c++) tick();
    check_output("timeout not yet", rd_timeout, 0);
    check_output("timeout busy waiting", busy, 1);
    tick();
    check_output("timeout flag", rd_timeout, 1);
    check_output("timeout busy", busy, 0);
    check_output("timeout valid", rd_valid, 0);
    dqs_t = 1'b0; dqs_c = 1'b1;
    tick();
    check_output("timeout sticky", rd_timeout, 1);

    // Five bursts into a depth-4 queue with the host stalled.
    for (int i = 0; i < 5; i++) begin
      b = 8'(i + 1);
      w = {8{b}};
      apply_stimulus(4'd8, 2'd1, 0, w, 8'h00, 1'b0, pb, pv);
      if (i == 3) check_output("overflow after 4", rd_overflow, 0);
    end
    check_output("overflow set", rd_overflow, 1);
    check_output("overflow valid", rd_valid, 1);
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b = 8'(i + 1);
      w = {8{b}};
      check_output($sformatf("drain word %0d", i), rd_data, w);
      tick();
    end
    rd_ready = 1'b0;
    check_output("drained valid", rd_valid, 0);
    check_output("overflow still set", rd_overflow, 1);

    // Async reset in the middle of CAPTURE with a word queued and flags set.
    apply_stimulus(4'd4, 2'd1, 0, 64'h00000000CAFEBABE, 8'h00, 1'b0, pb, pv);
    rd_start = 1'b1; preamble = 2'd1; burst_length = 4'd8;
    tick();
    rd_start = 1'b0;
    dqs_t = 1'b1; dqs_c = 1'b0;
    tick();
    dqs_t = 1'b0; dqs_c = 1'b1;
    for (int k = 0; k < 3; k++) begin
      dq = 8'hE0 + 8'(k);
      tick();
    end
    check_output("mid capture busy", busy, 1);
    check_output("mid capture valid", rd_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check_output("async reset valid", rd_valid, 0);
    check_output("async reset data", rd_data, 0);
    check_output("async reset busy", busy, 0);
    check_output("async reset timeout", rd_timeout, 0);
    check_output("async reset overflow", rd_overflow, 0);
    #1;
    reset = 1'b0;
    dq = 8'd0;
    tick();
    apply_stimulus(4'd8, 2'd1, 0, 64'h0123456789ABCDEF, 8'h00, 1'b0, pb, pv);
    check_output("post reset data", rd_data, 64'h0123456789ABCDEF);
    check_output("post reset valid", rd_valid, 1);

    // Push while full coincides with a pop: both happen, nothing is dropped.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      b = 8'h10 + 8'(i);
      w = {8{b}};
      apply_stimulus(4'd8, 2'd1, 0, w, 8'h00, (i == 4), pb, pv);
    end
    check_output("full push+pop overflow", rd_overflow, 0);
    rd_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      b = 8'h10 + 8'(i);
      w = {8{b}};
      check_output($sformatf("push+pop drain %0d", i), rd_data, w);
      tick();
    end
    check_output("push+pop drained", rd_valid, 0);
    tick();
    rd_ready = 1'b0;
    check_output("pop empty no-op", rd_valid, 0);
    check_output("pop empty data", rd_data, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
